// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
//  - state_t   : sequencer FSM states (IDLE, RUN, DONE)
//  - idx_width : width of the slice index counter for a given slice count
// No ports; imported by multiword_add_sequencer.
package multiword_add_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single slice still needs a one-bit index so the counter is never zero width.
    function automatic int idx_width(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_csa.sv
// carry_select_adder: N-bit combinational adder, {cout,sum} = a + b + cin.
// The upper half is computed for both possible carries and the real carry out
// of the lower half picks one, so the upper half does not wait on the lower ripple.
// Ports:
//  a, b  in  N  addends
//  cin   in  1  carry in
//  sum   out N  sum modulo 2^N
//  cout  out 1  carry out of bit N-1
module carry_select_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    generate
        if (N < 2) begin : g_single
            // A one-bit slice has nothing to split, so a plain add is used.
            assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};
        end else begin : g_split
            localparam int L = N / 2;
            localparam int H = N - L;

            logic [L:0] lo;
            logic [H:0] hi0;
            logic [H:0] hi1;

            assign lo  = {1'b0, a[L-1:0]} + {1'b0, b[L-1:0]} + {{L{1'b0}}, cin};
            assign hi0 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]};
            assign hi1 = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]} + {{H{1'b0}}, 1'b1};

            assign sum  = lo[L] ? {hi1[H-1:0], lo[L-1:0]} : {hi0[H-1:0], lo[L-1:0]};
            assign cout = lo[L] ? hi1[H] : hi0[H];
        end
    endgenerate

endmodule

// File: rtl/multiword_add_sequencer.sv
// multiword_add_sequencer: adds or subtracts two N*CHUNKS-bit operands one
// N-bit slice per cycle through a single carry_select_adder, least significant
// slice first, carrying between cycles. Valid/ready handshake on both sides,
// one operation in flight at a time.
// Ports:
//  clk, rst           clock, synchronous active-high reset
//  in_valid/in_ready  operand handshake
//  in_a, in_b         operands (W bits)
//  in_cin             carry in (ignored when subtracting)
//  in_sub             1 = compute in_a - in_b
//  out_valid/out_ready result handshake
//  out_sum            result modulo 2^W
//  out_cout           carry out of the top slice (subtract: 1 = no borrow)
//  out_ovf            two's-complement overflow
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int N      = 8,
    parameter int CHUNKS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N*CHUNKS-1:0]   in_a,
    input  logic [N*CHUNKS-1:0]   in_b,
    input  logic                  in_cin,
    input  logic                  in_sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N*CHUNKS-1:0]   out_sum,
    output logic                  out_cout,
    output logic                  out_ovf
);

    localparam int             W    = N * CHUNKS;
    localparam int             IW   = idx_width(CHUNKS);
    localparam logic [IW-1:0]  LAST = IW'(CHUNKS - 1);

    state_t          state;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    sum_reg;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [N-1:0]    slice_a;
    logic [N-1:0]    slice_b;
    logic [N-1:0]    slice_sum;
    logic            slice_cout;

    // Slice mux: the current index picks which N-bit window of each latched
    // operand goes through the shared adder this cycle.
    assign slice_a = op_a[int'(idx)*N +: N];
    assign slice_b = op_b[int'(idx)*N +: N];

    carry_select_adder #(.N(N)) u_adder (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    assign out_sum = sum_reg;

    // Sequencer FSM. op_b is stored already inverted for subtraction so RUN
    // never needs to know the operation. Overflow is formed on the final slice
    // from the operand sign bits and the freshly computed result sign bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            sum_reg   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        op_a     <= in_a;
                        op_b     <= in_sub ? ~in_b : in_b;
                        carry    <= in_sub ? 1'b1 : in_cin;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[int'(idx)*N +: N] <= slice_sum;
                    carry                     <= slice_cout;
                    if (idx == LAST) begin
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_cout  <= slice_cout;
                        out_ovf   <= (op_a[W-1] == op_b[W-1]) && (slice_sum[N-1] != op_a[W-1]);
                        state     <= DONE;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer (N=8, CHUNKS=4).
// Directed cases followed by randomized operations, all checked against a
// reference model that works on whole operands with integer arithmetic.
module tb_multiword_add_sequencer;

    localparam int N      = 8;
    localparam int CHUNKS = 4;
    localparam int W      = N * CHUNKS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic          in_sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic          out_cout;
    logic          out_ovf;

    int assertCount = 0;
    int failCount   = 0;

    multiword_add_sequencer #(.N(N), .CHUNKS(CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Safety net so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: whole-operand integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [W+1:0] refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic cin, input logic sub);
        longint ua, ub, sa, sb, full, sres;
        longint maxS, minS;
        logic   cout, ovf;
        logic [W-1:0] s;
        ua   = longint'(a);
        ub   = longint'(b);
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        maxS = (longint'(1) <<< (W - 1)) - 1;
        minS = -(longint'(1) <<< (W - 1));
        if (sub) begin
            full = ua - ub;
            cout = (ua >= ub);
            sres = sa - sb;
        end else begin
            full = ua + ub + longint'(cin);
            cout = (full >= (longint'(1) <<< W));
            sres = sa + sb + longint'(cin);
        end
        s   = full[W-1:0];
        ovf = (sres > maxS) || (sres < minS);
        return {ovf, cout, s};
    endfunction

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    task automatic checkWord(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkInt(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Present one operand bundle, wait for acceptance, scramble the inputs
    // afterwards and count cycles until out_valid rises.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, output int latency);
        int waited;
        bit accepted;
        waited   = 0;
        accepted = 1'b0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        while (!accepted && waited < 100) begin
            accepted = (in_ready === 1'b1);
            tick;
            waited++;
        end
        in_valid = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom_range(0, 1));
        in_sub   = 1'($urandom_range(0, 1));
        checkBit("accept", accepted, 1'b1);
        latency = 0;
        while (out_valid !== 1'b1 && latency < 100) begin
            out_ready = 1'($urandom_range(0, 1));
            tick;
            latency++;
        end
        out_ready = 1'b0;
    endtask

    // Check a presented result against the model, hold it under backpressure
    // for 'hold' cycles, then complete the handshake and check release.
    task automatic checkOutput(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic cin, input logic sub, input int hold);
        logic [W+1:0] exp;
        exp       = refModel(a, b, cin, sub);
        out_ready = 1'b0;
        checkBit({tag, "_valid"}, out_valid, 1'b1);
        checkWord({tag, "_sum"}, out_sum, exp[W-1:0]);
        checkBit({tag, "_cout"}, out_cout, exp[W]);
        checkBit({tag, "_ovf"}, out_ovf, exp[W+1]);
        for (int i = 0; i < hold; i++) begin
            tick;
            checkBit({tag, "_hold_valid"}, out_valid, 1'b1);
            checkWord({tag, "_hold_sum"}, out_sum, exp[W-1:0]);
            checkBit({tag, "_hold_cout"}, out_cout, exp[W]);
            checkBit({tag, "_hold_ovf"}, out_ovf, exp[W+1]);
            checkBit({tag, "_hold_in_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        checkBit({tag, "_released"}, out_valid, 1'b0);
        checkBit({tag, "_in_ready_after"}, in_ready, 1'b1);
    endtask

    // Directed results with values written out by hand.
    task automatic checkConst(input string tag, input logic [W-1:0] s, input logic c, input logic o);
        checkWord({tag, "_const_sum"}, out_sum, s);
        checkBit({tag, "_const_cout"}, out_cout, c);
        checkBit({tag, "_const_ovf"}, out_ovf, o);
    endtask

    // Main sequence: reset, directed cases, reset abort, random traffic.
    initial begin
        int lat;
        logic [W-1:0] ra, rb;
        logic rc, rs;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
        repeat (3) tick;
        checkBit("rst_out_valid", out_valid, 1'b0);
        checkWord("rst_out_sum", out_sum, '0);
        checkBit("rst_out_cout", out_cout, 1'b0);
        checkBit("rst_out_ovf", out_ovf, 1'b0);
        checkBit("rst_in_ready", in_ready, 1'b1);
        rst = 1'b0;
        tick;
        checkBit("idle_in_ready", in_ready, 1'b1);

        $display("[TB] case 1: carry ripple through all slices");
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        checkInt("t1_latency", lat, CHUNKS);
        checkConst("t1", 32'h0000_0000, 1'b1, 1'b0);
        checkOutput("t1", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);

        $display("[TB] case 2: signed add overflow");
        applyStimulus(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        checkInt("t2_latency", lat, CHUNKS);
        checkConst("t2", 32'h8000_0000, 1'b0, 1'b1);
        checkOutput("t2", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);

        $display("[TB] case 3: subtraction, carry-in ignored");
        applyStimulus(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, lat);
        checkConst("t3a", 32'hFFFF_FFFE, 1'b0, 1'b0);
        checkOutput("t3a", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 0);
        applyStimulus(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, lat);
        checkConst("t3b", 32'h7FFF_FFFF, 1'b1, 1'b1);
        checkOutput("t3b", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 0);

        $display("[TB] case 4: backpressure hold");
        applyStimulus(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, lat);
        checkOutput("t4", 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 5);

        $display("[TB] case 4b: output handshake with simultaneous in_valid");
        applyStimulus(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, lat);
        checkConst("t4b", 32'h0000_0100, 1'b0, 1'b0);
        in_a = 32'h0000_0001; in_b = 32'h0000_0001; in_cin = 1'b0; in_sub = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checkBit("t4b_not_accepted", in_ready, 1'b1);
        checkBit("t4b_out_valid", out_valid, 1'b0);
        applyStimulus(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, lat);
        checkInt("t4b_latency", lat, CHUNKS);
        checkOutput("t4b_next", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 0);

        $display("[TB] case 5: reset during RUN");
        checkBit("t5_ready_before", in_ready, 1'b1);
        in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_cin = 1'b1; in_sub = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        checkBit("t5_out_valid", out_valid, 1'b0);
        checkBit("t5_in_ready", in_ready, 1'b1);
        for (int i = 0; i < CHUNKS + 2; i++) begin
            tick;
            checkBit("t5_no_partial", out_valid, 1'b0);
        end
        applyStimulus(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, lat);
        checkInt("t5_latency", lat, CHUNKS);
        checkConst("t5", 32'h0000_0003, 1'b0, 1'b0);
        checkOutput("t5", 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 0);

        $display("[TB] case 6: randomized traffic");
        for (int k = 0; k < 40; k++) begin
            repeat ($urandom_range(0, 3)) tick;
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: ra = 32'hFFFF_FFFF;
                1: rb = 32'h8000_0000;
                2: ra = 32'h7FFF_FFFF;
                default: ;
            endcase
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rc, rs, lat);
            checkInt("t6_latency", lat, CHUNKS);
            checkOutput("t6", ra, rb, rc, rs, $urandom_range(0, 4));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
